// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Single-clock RAM filled from a UART RX byte stream, zero-cleared on
//   request, browsed by switch address or auto-scanned for display.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   mode       00 browse, 01 scan, 10 load, 11 clear
//   sel_addr   switch address (browse address / scan start)
//   rd_addr    address currently displayed
//   rd_data    RAM word at rd_addr (one cycle behind rd_addr)
//   busy       high while a clear is running
//   load_done  one-cycle pulse after the last address is written in load
//
// Write-side FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no writes; waits for mode 10 (load) or a fresh mode 11
//   ST_LOAD  | assembling LSB-first words from rx bytes, writing waddr++
//   ST_CLEAR | writing zero to every address, one per cycle, busy high
//
// Read side is independent of the FSM and follows mode directly, so a
// load or clear in progress is visible live at rd_addr.

module uart_mem_loader #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 8,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] sel_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              load_done
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int WB     = NBYTES * 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] MODE_BROWSE = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WB-1:0]       word_q, word_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;
  logic                clr_lock_q, clr_lock_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic                we;
  logic [DATA_W-1:0]   wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Write side: load / clear sequencing
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    clr_lock_d  = clr_lock_q;
    we          = 1'b0;
    wdata       = '0;

    // A clear only re-arms once mode has been seen away from 11 outside a
    // clear, so holding 11 after completion does not start another pass.
    if (state_q != ST_CLEAR && mode != MODE_CLEAR) clr_lock_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_LOAD) begin
          state_d    = ST_LOAD;
          waddr_d    = '0;
          byte_idx_d = '0;
          word_d     = '0;
        end else if (mode == MODE_CLEAR && !clr_lock_q) begin
          state_d    = ST_CLEAR;
          waddr_d    = '0;
          busy_d     = 1'b1;
          clr_lock_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (mode != MODE_LOAD) begin
          // partial word is dropped; nothing is written from it
          state_d    = ST_IDLE;
          byte_idx_d = '0;
        end else if (rx_valid) begin
          // shift right so the first byte of a word lands in the low byte
          word_d = WB'({rx_data, word_q} >> 8);
          if (byte_idx_q == LAST_BYTE) begin
            we         = 1'b1;
            wdata      = word_d[DATA_W-1:0];
            waddr_d    = waddr_q + 1'b1;
            byte_idx_d = '0;
            if (waddr_q == '1) load_done_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        we      = 1'b1;
        wdata   = '0;
        waddr_d = waddr_q + 1'b1;
        if (waddr_q == '1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Read side: browse / scan address generation
  always_comb begin
    rd_addr_d = rd_addr_q;
    div_d     = div_q;
    case (mode)
      MODE_BROWSE: rd_addr_d = sel_addr;
      MODE_SCAN: begin
        if (mode_q != MODE_SCAN) begin
          rd_addr_d = sel_addr;
          div_d     = DIV_LOAD;
        end else if (div_q == '0) begin
          rd_addr_d = rd_addr_q + 1'b1;
          div_d     = DIV_LOAD;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: rd_addr_d = rd_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BROWSE;
      waddr_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      clr_lock_q  <= 1'b0;
      rd_addr_q   <= '0;
      div_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode;
      waddr_q     <= waddr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      clr_lock_q  <= clr_lock_d;
      rd_addr_q   <= rd_addr_d;
      div_q       <= div_d;
      rd_data_q   <= mem[rd_addr_q];
    end
  end

  // RAM array has no reset; a same-address write returns old data on read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr_q] <= wdata;
  end

  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 8;
  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 256;
  localparam int NBYTES   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              load_done;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mode     (mode),
    .sel_addr (sel_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .load_done(load_done)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (load_done === 1'b1) done_cnt <= done_cnt + 1;

  // reference model: memory image plus load-side byte assembly
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                known   [DEPTH];
  int                m_waddr;
  logic [7:0]        m_bytes [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [31:0] w;
    repeat ($urandom_range(0, 1)) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    m_bytes.push_back(b);
    if (m_bytes.size() == NBYTES) begin
      w = '0;
      for (int j = 0; j < NBYTES; j++) w |= 32'(m_bytes[j]) << (8 * j);
      ref_mem[m_waddr] = w[DATA_W-1:0];
      known[m_waddr]   = 1'b1;
      m_waddr          = (m_waddr + 1) % DEPTH;
      m_bytes.delete();
    end
  endtask

  task automatic enter_load();
    mode = 2'b10;
    tick();
    tick();
    m_waddr = 0;
    m_bytes.delete();
  endtask

  task automatic to_browse();
    mode = 2'b00;
    tick();
    m_bytes.delete();
  endtask

  task automatic browse_chk(input int a, input string tag);
    sel_addr = 8'(a);
    tick();
    tick();
    if (known[a]) chk(tag, 32'(rd_data), 32'(ref_mem[a]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    int exp_a, prev_a;
    logic [9:0] w;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b0;
    end
    m_waddr  = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    mode     = 2'b01;
    sel_addr = 8'h37;

    // 1: reset with scan mode and rx traffic, then scan from sel_addr
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tick();
    end
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_done", 32'(load_done), 0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("scan_start", 32'(rd_addr), 32'h37);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("scan_rst", 32'(rd_addr), 32'((8'h37 + k / SCAN_DIV) % DEPTH));
    end

    // 2: two words, then browse latency
    enter_load();
    send_byte(8'h34); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
    to_browse();
    browse_chk(1, "browse_3ff");
    chk("browse_3ff_const", 32'(rd_data), 32'h3FF);
    sel_addr = 8'h00;
    tick();
    chk("browse_lat1", 32'(rd_data), 32'h3FF);
    tick();
    chk("browse_lat2", 32'(rd_data), 32'h234);

    // 3: full fill, load_done pulse, wrap overwrite
    enter_load();
    base = done_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      send_byte(8'(k));
      if (k == DEPTH - 1) begin
        chk("done_early", 32'(load_done), 0);
      end
      send_byte(8'h00);
    end
    chk("done_pulse", 32'(load_done), 1);
    tick();
    chk("done_fall", 32'(load_done), 0);
    chk("done_count", 32'(done_cnt - base), 1);
    send_byte(8'h55); send_byte(8'h01);
    to_browse();
    browse_chk(0, "wrap_155");
    chk("wrap_155_const", 32'(rd_data), 32'h155);
    for (int i = 0; i < 6; i++) browse_chk($urandom_range(1, DEPTH - 1), "fill_rand");

    // 4: clear with mode toggling and ignored rx traffic
    mode = 2'b11;
    tick();
    chk("busy_rise", 32'(busy), 1);
    cnt = 1;
    while (busy === 1'b1 && cnt < 600) begin
      if (cnt == 50) mode = 2'b00;
      if (cnt == 60) mode = 2'b11;
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tick();
      if (busy === 1'b1) cnt++;
    end
    rx_valid = 1'b0;
    chk("busy_len", 32'(cnt), DEPTH);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_reclear", 32'(busy), 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b1;
    end
    to_browse();
    for (int a = 0; a < DEPTH; a++) browse_chk(a, "clear_zero");

    // 5: random fill (excess high bits dropped), then scan across the wrap
    enter_load();
    base = done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      w = 10'($urandom);
      send_byte(w[7:0]);
      send_byte({6'($urandom), w[9:8]});
    end
    tick();
    chk("done_count2", 32'(done_cnt - base), 1);
    mode     = 2'b01;
    sel_addr = 8'hFE;
    tick();
    m_bytes.delete();
    chk("scan_entry", 32'(rd_addr), 32'hFE);
    prev_a = 8'hFE;
    for (int k = 1; k <= 16; k++) begin
      sel_addr = 8'($urandom);
      tick();
      exp_a = (8'hFE + k / SCAN_DIV) % DEPTH;
      chk("scan_addr", 32'(rd_addr), 32'(exp_a));
      chk("scan_data", 32'(rd_data), 32'(ref_mem[prev_a]));
      prev_a = exp_a;
    end

    // 6: aborted partial word, reload, then reset mid-clear
    to_browse();
    enter_load();
    send_byte(8'h77);
    to_browse();
    enter_load();
    send_byte(8'h12); send_byte(8'h00);
    to_browse();
    browse_chk(0, "partial_012");
    chk("partial_012_const", 32'(rd_data), 32'h012);
    browse_chk(1, "partial_keep");
    mode = 2'b11;
    repeat (40) tick();
    chk("busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    for (int i = 0; i < 30; i++) ref_mem[i] = '0;
    for (int i = 30; i < 50; i++) known[i] = 1'b0;
    mode = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    browse_chk(0, "abort_cleared");
    browse_chk(29, "abort_cleared");
    browse_chk(8'h80, "abort_kept");
    browse_chk(8'hC8, "abort_kept");
    browse_chk(8'hFF, "abort_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
